// File: rtl/seg7_scan_decoder.sv
// Scanned 7-segment bus reader: deglitches each {SEG,DIG} pattern and recovers one
// hex nibble per digit, with sticky error flag and a frame-complete pulse.
module seg7_scan_decoder #(
   parameter int N_DIG      = 4,
   parameter int STABLE_CYC = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [6:0]         SEG,
   input  logic [N_DIG-1:0]   DIG,
   input  logic               ERR_CLR,
   output logic [4*N_DIG-1:0] BCD_OUT,
   output logic [N_DIG-1:0]   VALID,
   output logic               ERR,
   output logic               FRAME
);

   localparam int CNT_W = $clog2(STABLE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);
   localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(STABLE_CYC - 1);

   logic [6:0]         seg_q;
   logic [N_DIG-1:0]   dig_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [4*N_DIG-1:0] bcd_q, bcd_d;
   logic [N_DIG-1:0]   valid_q, valid_d;
   logic [N_DIG-1:0]   seen_q, seen_d;
   logic               err_q, err_d;
   logic               frame_q, frame_d;

   logic               same, accept, multi, err_set;
   logic               dec_ok, dec_blank;
   logic [3:0]         dec_nib;

   always_comb begin
      dec_ok    = 1'b1;
      dec_blank = 1'b0;
      dec_nib   = 4'h0;
      case (SEG)
         7'h7E: dec_nib = 4'h0;
         7'h30: dec_nib = 4'h1;
         7'h6D: dec_nib = 4'h2;
         7'h79: dec_nib = 4'h3;
         7'h33: dec_nib = 4'h4;
         7'h5B: dec_nib = 4'h5;
         7'h5F: dec_nib = 4'h6;
         7'h70: dec_nib = 4'h7;
         7'h7F: dec_nib = 4'h8;
         7'h7B: dec_nib = 4'h9;
         7'h77: dec_nib = 4'hA;
         7'h1F: dec_nib = 4'hB;
         7'h4E: dec_nib = 4'hC;
         7'h3D: dec_nib = 4'hD;
         7'h4F: dec_nib = 4'hE;
         7'h47: dec_nib = 4'hF;
         7'h00: begin
            dec_ok    = 1'b0;
            dec_blank = 1'b1;
         end
         default: dec_ok = 1'b0;
      endcase
   end

   always_comb begin
      same    = (SEG == seg_q) && (DIG == dig_q);
      accept  = same && (cnt_q == CNT_ACC);
      multi   = (DIG & (DIG - N_DIG'(1))) != '0;
      cnt_d   = !same ? CNT_W'(1) : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1));
      bcd_d   = bcd_q;
      valid_d = valid_q;
      seen_d  = seen_q;
      frame_d = 1'b0;
      err_set = 1'b0;

      if (accept && (DIG != '0)) begin
         if (multi) begin
            err_set = 1'b1;
         end else begin
            for (int i = 0; i < N_DIG; i++) begin
               if (DIG[i]) begin
                  seen_d[i] = 1'b1;
                  if (dec_ok) begin
                     bcd_d[4*i +: 4] = dec_nib;
                     valid_d[i]      = 1'b1;
                  end else begin
                     valid_d[i] = 1'b0;
                     if (!dec_blank) err_set = 1'b1;
                  end
               end
            end
         end
      end

      // Completing the frame restarts the seen-mask on the same edge.
      if (seen_d == '1) begin
         frame_d = 1'b1;
         seen_d  = '0;
      end

      err_d = ERR_CLR ? 1'b0 : err_q;
      if (err_set) err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q   <= '0;
         dig_q   <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
         valid_q <= '0;
         seen_q  <= '0;
         err_q   <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         seg_q   <= SEG;
         dig_q   <= DIG;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         valid_q <= valid_d;
         seen_q  <= seen_d;
         err_q   <= err_d;
         frame_q <= frame_d;
      end
   end

   assign BCD_OUT = bcd_q;
   assign VALID   = valid_q;
   assign ERR     = err_q;
   assign FRAME   = frame_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: deglitch latency, decode, blank/error,
// multi-hot, frame pulse and mid-dwell reset.
module tb_seg7_scan_decoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  SEG;
   logic [3:0]  DIG;
   logic        ERR_CLR;
   logic [15:0] BCD_OUT;
   logic [3:0]  VALID;
   logic        ERR;
   logic        FRAME;

   int n_checks = 0;
   int n_err    = 0;
   int frame_cnt = 0;
   int frame_base;

   seg7_scan_decoder #(.N_DIG(4), .STABLE_CYC(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .SEG     (SEG),
      .DIG     (DIG),
      .ERR_CLR (ERR_CLR),
      .BCD_OUT (BCD_OUT),
      .VALID   (VALID),
      .ERR     (ERR),
      .FRAME   (FRAME)
   );

   // clock / reset
   always #5 clk = ~clk;

   always @(negedge clk) if (FRAME === 1'b1) frame_cnt++;

   // driver tasks: inputs change and outputs are sampled on the falling edge
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic [3:0] dig, input logic [6:0] seg);
      DIG = dig;
      SEG = seg;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic [15:0] bcd, input logic [3:0] vld,
                           input logic err);
      chk({tag, "_bcd"}, 32'(BCD_OUT), 32'(bcd));
      chk({tag, "_valid"}, 32'(VALID), 32'(vld));
      chk({tag, "_err"}, 32'(ERR), 32'(err));
   endtask

   initial begin
      rst_n   = 1'b0;
      ERR_CLR = 1'b0;
      drive(4'b0000, 7'h00);
      tick(2);
      chk_outs("reset", 16'h0000, 4'b0000, 1'b0);
      chk("reset_frame", 32'(FRAME), 32'd0);

      // 1: first accept lands exactly on the 4th edge
      rst_n = 1'b1;
      drive(4'b0001, 7'h6D);
      tick(3);
      chk("lat_early_valid", 32'(VALID), 32'd0);
      tick(1);
      chk_outs("lat_accept", 16'h0002, 4'b0001, 1'b0);

      // 2: 3-cycle glitch is ignored, then 4-cycle dwell accepted once
      drive(4'b0010, 7'h79);
      tick(3);
      drive(4'b0010, 7'h33);
      tick(3);
      chk_outs("glitch_none", 16'h0002, 4'b0001, 1'b0);
      tick(1);
      chk_outs("glitch_acc", 16'h0042, 4'b0011, 1'b0);
      frame_base = frame_cnt;
      tick(20);
      chk_outs("hold_long", 16'h0042, 4'b0011, 1'b0);
      chk("hold_noframe", 32'(frame_cnt), 32'(frame_base));

      // 3: full frame 0..3
      drive(4'b0001, 7'h7E); tick(5);
      drive(4'b0010, 7'h30); tick(5);
      drive(4'b0100, 7'h77); tick(5);
      chk("frame_not_yet", 32'(frame_cnt), 32'(frame_base));
      drive(4'b1000, 7'h47); tick(4);
      chk("frame_pulse", 32'(FRAME), 32'd1);
      tick(1);
      chk("frame_drop", 32'(FRAME), 32'd0);
      chk_outs("frame_data", 16'hFA10, 4'b1111, 1'b0);
      chk("frame_once", 32'(frame_cnt), 32'(frame_base + 1));

      // 4: blank, bad pattern, set beats clear
      drive(4'b0100, 7'h00); tick(4);
      chk_outs("blank", 16'hFA10, 4'b1011, 1'b0);
      drive(4'b0100, 7'h01); tick(4);
      chk_outs("bad_seg", 16'hFA10, 4'b1011, 1'b1);
      drive(4'b0100, 7'h02); tick(3);
      ERR_CLR = 1'b1; tick(1); ERR_CLR = 1'b0;
      chk("set_over_clr", 32'(ERR), 32'd1);
      ERR_CLR = 1'b1; tick(1); ERR_CLR = 1'b0;
      chk("clr_alone", 32'(ERR), 32'd0);

      // 5: multi-hot flags error without touching digits or the seen-mask
      frame_base = frame_cnt;
      drive(4'b0011, 7'h30); tick(4);
      chk_outs("multi_hot", 16'hFA10, 4'b1011, 1'b1);
      ERR_CLR = 1'b1; tick(1); ERR_CLR = 1'b0;
      drive(4'b0000, 7'h7E); tick(6);
      chk_outs("blank_gap", 16'hFA10, 4'b1011, 1'b0);
      drive(4'b1000, 7'h4F); tick(5);
      chk("multi_no_seen", 32'(frame_cnt), 32'(frame_base));
      drive(4'b0001, 7'h5B); tick(5);
      drive(4'b0010, 7'h1F); tick(5);
      chk_outs("frame2_data", 16'hEAB5, 4'b1011, 1'b0);
      chk("frame2_pulse", 32'(frame_cnt), 32'(frame_base + 1));

      // 6: reset mid-dwell discards the partial count
      drive(4'b0001, 7'h7F); tick(2);
      rst_n = 1'b0; tick(1);
      chk_outs("mid_rst", 16'h0000, 4'b0000, 1'b0);
      chk("mid_rst_frame", 32'(FRAME), 32'd0);
      rst_n = 1'b1;
      tick(3);
      chk_outs("post_rst_early", 16'h0000, 4'b0000, 1'b0);
      tick(1);
      chk_outs("post_rst_acc", 16'h0008, 4'b0001, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
